load_store_unit: RTL and testbench

Load/store unit between the core's execute stage and the byte-write-enabled, one-cycle-read-latency data RAM. Takes one memory request at a time and generates the word address, read strobe, 4-bit byte write enables and lane-aligned store data. Splits word/halfword accesses that cross a 32-bit boundary into two RAM accesses. Merges, shifts and sign/zero-extends load data before returning a single registered response.

---
 rtl/lsu_pkg.sv | 15 +
 rtl/lsu_if.sv | 25 ++
 rtl/lsu_align.sv | 33 +++
 rtl/load_store_unit.sv | 85 ++++++++
 tb/tb_load_store_unit.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM state type and access-size helpers for the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {IDLE, ACC0, ACC1, FIN, RESP} state_t;
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    return f3[1:0] == 2'b00 ? 4'h1 : f3[1:0] == 2'b01 ? 4'h3 : 4'hF;
  endfunction
  function automatic logic legal(input logic we, input logic [2:0] f3);
    return we ? f3 <= F3_W : (f3 <= F3_W || f3 == F3_BU || f3 == F3_HU);
  endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: request/response handshake and data RAM port of the load/store unit
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [3:0]  mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_read, mem_write, mem_wdata
  );
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: store lane/byte-enable generation and load merge, shift and extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] buf0,
  output logic        split,
  output logic [7:0]  be64,
  output logic [63:0] data64,
  output logic [31:0] ldata
);
  logic [3:0]  m;
  logic [31:0] wmask;
  logic [55:0] w56;
  logic [31:0] sh;
  always_comb begin
    m      = size_mask(funct3);
    wmask  = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    be64   = {4'b0, m} << off;
    data64 = {32'b0, wdata & wmask} << {off, 3'b000};
    split  = |be64[7:4];
    // byte 7 of the merged pair can never be selected, so only 56 bits are kept
    w56    = split ? {mem_rdata[23:0], buf0} : {24'b0, mem_rdata};
    sh     = w56[{off, 3'b000} +: 32];
    ldata  = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
             funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
             funct3 == F3_BU ? {24'b0, sh[7:0]} :
             funct3 == F3_HU ? {16'b0, sh[15:0]} : sh;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store sequencer with split unaligned accesses
module load_store_unit
  import lsu_pkg::*;
(
  input logic clk,
  input logic rst,
  lsu_if.slave bus
);
  state_t      state, state_n;
  logic        we_q, err_q, split;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, buf0, rdata_q, ldata, word0;
  logic [7:0]  be64;
  logic [63:0] data64;
  lsu_align u_align (
    .funct3(f3_q), .off(addr_q[1:0]), .wdata(wdata_q), .mem_rdata(bus.mem_rdata),
    .buf0(buf0), .split(split), .be64(be64), .data64(data64), .ldata(ldata)
  );
  assign word0         = {addr_q[31:2], 2'b00};
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  always_comb begin
    state_n       = state;
    bus.req_ready = state == IDLE;
    bus.rsp_valid = state == RESP && !rst;
    bus.mem_addr  = '0;
    bus.mem_read  = 1'b0;
    bus.mem_write = '0;
    bus.mem_wdata = '0;
    case (state)
      IDLE: if (bus.req_valid) state_n = legal(bus.req_we, bus.req_funct3) ? ACC0 : RESP;
      ACC0: begin
        bus.mem_addr  = word0;
        bus.mem_read  = !we_q;
        bus.mem_write = we_q ? be64[3:0] : 4'b0;
        bus.mem_wdata = we_q ? data64[31:0] : 32'b0;
        state_n       = split ? ACC1 : FIN;
      end
      ACC1: begin
        bus.mem_addr  = word0 + 32'd4;
        bus.mem_read  = !we_q;
        bus.mem_write = we_q ? be64[7:4] : 4'b0;
        bus.mem_wdata = we_q ? data64[63:32] : 32'b0;
        state_n       = FIN;
      end
      FIN:     state_n = RESP;
      default: state_n = IDLE;
    endcase
    if (rst) begin
      bus.mem_addr  = '0;
      bus.mem_read  = 1'b0;
      bus.mem_write = '0;
      bus.mem_wdata = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      buf0    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.req_valid) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        if (!legal(bus.req_we, bus.req_funct3)) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
      if (state == ACC1 && !we_q) buf0 <= bus.mem_rdata;
      if (state == FIN) begin
        rdata_q <= we_q ? 32'b0 : ldata;
        err_q   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks against a byte-memory reference model
module tb_load_store_unit;
  logic clk = 0, rst = 1, clr = 1, pl_en = 0;
  logic [9:0] pl_addr = 0;
  logic [7:0] pl_data = 0;
  logic [7:0] ram [0:1023];
  logic [7:0] refm [0:1023];
  logic [31:0] tr_addr [1:10];
  logic [3:0]  tr_we [1:10];
  logic        tr_rd [1:10];
  logic [31:0] tr_wd [1:10];
  int n_chk = 0, n_fail = 0;
  lsu_if bus();
  load_store_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [9:0] ix(input logic [31:0] a);
    return a[9:0];
  endfunction
  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 1024; i++) ram[i] <= 8'h0;
    if (pl_en) ram[pl_addr] <= pl_data;
    for (int i = 0; i < 4; i++)
      if (bus.mem_write[i]) ram[ix(bus.mem_addr + 32'(i))] <= bus.mem_wdata[8*i +: 8];
    if (bus.mem_read)
      bus.mem_rdata <= {ram[ix(bus.mem_addr + 3)], ram[ix(bus.mem_addr + 2)],
                        ram[ix(bus.mem_addr + 1)], ram[ix(bus.mem_addr)]};
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic pre(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      refm[ix(a + 32'(i))] = w[8*i +: 8];
      pl_en = 1; pl_addr = ix(a + 32'(i)); pl_data = w[8*i +: 8];
      @(negedge clk);
    end
    pl_en = 0;
  endtask
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] er, output logic ee, output int el, output int eacc);
    int sz;
    logic [31:0] v;
    ee = we ? f3 > 3'd2 : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz = 1 << f3[1:0];
    er = 0; el = 1; eacc = 0;
    if (!ee) begin
      el   = (int'(a[1:0]) + sz > 4) ? 4 : 3;
      eacc = el - 2;
      if (we) for (int i = 0; i < sz; i++) refm[ix(a + 32'(i))] = wd[8*i +: 8];
      else begin
        v = 0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = refm[ix(a + 32'(i))];
        if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
        if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
        er = v;
      end
    end
  endtask
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] er, got_d;
    logic ee, got_e, seen, rdy_bad;
    int el, eacc, n, nacc, sz;
    model(we, f3, a, wd, er, ee, el, eacc);
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    seen = 0; rdy_bad = 0; n = 99; nacc = 0; got_d = 'x; got_e = 'x;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 0;
      tr_addr[c] = bus.mem_addr; tr_we[c] = bus.mem_write; tr_rd[c] = bus.mem_read; tr_wd[c] = bus.mem_wdata;
      if (bus.mem_read || bus.mem_write != 0) nacc++;
      if (bus.req_ready) rdy_bad = 1;
      if (bus.rsp_valid) begin
        seen = 1; n = c; got_d = bus.rsp_rdata; got_e = bus.rsp_err;
      end
    end
    chk("latency", n, el);
    chk("rsp_rdata", got_d, er);
    chk("rsp_err", {31'b0, got_e}, {31'b0, ee});
    chk("mem_accesses", nacc, eacc);
    chk("req_ready_busy", {31'b0, rdy_bad}, 0);
    sz = 1 << f3[1:0];
    if (we && !ee)
      for (int i = -1; i <= sz; i++) chk("ram_byte", ram[ix(a + 32'(i))], refm[ix(a + 32'(i))]);
  endtask
  initial begin
    logic bad;
    bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0; bus.req_addr = 0; bus.req_wdata = 0;
    for (int i = 0; i < 1024; i++) refm[i] = 8'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, bus.req_ready}, 1);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 0);
    chk("rst_mem_strobes", {27'b0, bus.mem_read, bus.mem_write}, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    rst = 0; clr = 0;
    @(negedge clk);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", {31'b0, bus.rsp_err}, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    run(1, 3'd2, 32'h100, 32'hDEADBEEF);
    chk("sw_be", tr_we[1], 4'hF);
    chk("sw_addr", tr_addr[1], 32'h100);
    run(0, 3'd2, 32'h100, 0);
    run(1, 3'd0, 32'h103, 32'hA5);
    chk("sb_be", tr_we[1], 4'h8);
    chk("sb_lane", tr_wd[1][31:24], 8'hA5);
    run(0, 3'd0, 32'h103, 0);
    run(0, 3'd4, 32'h103, 0);
    pre(32'h100, 32'h44332211);
    pre(32'h104, 32'h88776655);
    run(0, 3'd2, 32'h102, 0);
    chk("lw_split_a0", tr_addr[1], 32'h100);
    chk("lw_split_a1", tr_addr[2], 32'h104);
    chk("lw_split_rd", {30'b0, tr_rd[1], tr_rd[2]}, 3);
    run(0, 3'd1, 32'h103, 0);
    run(1, 3'd1, 32'h107, 32'h1234BEEF);
    chk("sh_a0", tr_addr[1], 32'h104);
    chk("sh_be0", tr_we[1], 4'h8);
    chk("sh_b0", tr_wd[1][31:24], 8'hEF);
    chk("sh_a1", tr_addr[2], 32'h108);
    chk("sh_be1", tr_we[2], 4'h1);
    chk("sh_b1", tr_wd[2][7:0], 8'hBE);
    run(0, 3'd5, 32'h107, 0);
    pre(32'hFFFFFFFC, 32'h22110000);
    pre(32'h0, 32'h00004433);
    run(0, 3'd2, 32'hFFFFFFFE, 0);
    chk("wrap_a0", tr_addr[1], 32'hFFFFFFFC);
    chk("wrap_a1", tr_addr[2], 32'h0);
    run(0, 3'd3, 32'h100, 0);
    run(1, 3'd4, 32'h100, 32'h12345678);
    // abort a split load while its second word is on the bus
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = 0; bus.req_funct3 = 3'd2; bus.req_addr = 32'h102;
    @(negedge clk);
    bus.req_valid = 0;
    @(negedge clk);
    chk("acc1_addr", bus.mem_addr, 32'h104);
    rst = 1;
    #1;
    chk("rst_acc1_read", {31'b0, bus.mem_read}, 0);
    chk("rst_acc1_addr", bus.mem_addr, 0);
    @(negedge clk);
    rst = 0;
    chk("post_rst_ready", {31'b0, bus.req_ready}, 1);
    bad = 0;
    repeat (5) begin
      if (bus.rsp_valid) bad = 1;
      @(negedge clk);
    end
    chk("post_rst_no_rsp", {31'b0, bad}, 0);
    for (int k = 0; k < 250; k++) begin
      logic [31:0] base;
      case ($urandom_range(0, 2))
        0: base = 32'h100;
        1: base = 32'h200;
        default: base = 32'hFFFFFFC0;
      endcase
      run(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), base + 32'($urandom_range(0, 63)), $urandom);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
